// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the up-counter health monitor.
package count_mon_pkg;

   // Monitor tracking state
   typedef enum logic {
      TRACK,
      FAULT
   } mon_state_t;

   // Increment that stops at 2^width-1 instead of rolling over (width <= 32)
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input int unsigned width);
      logic [31:0] max_val;
      max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
      return (value >= max_val) ? max_val : value + 32'd1;
   endfunction

endpackage

// File: rtl/count_monitor.sv
// Passive checker beside an up-counter: keeps its own model of the count,
// flags deviations, and counts errors and model wrap-arounds.
module count_monitor
   import count_mon_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned ERR_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] count,
   input  logic             resync,
   output logic [WIDTH-1:0] expected,
   output logic             mismatch,
   output logic             fault,
   output logic [ERR_W-1:0] error_count,
   output logic             wrap_pulse,
   output logic [ERR_W-1:0] wrap_count
);

   mon_state_t       state;
   logic             cmp;
   logic             wrap_hit;
   logic [WIDTH-1:0] wrap_src;
   logic [ERR_W-1:0] err_inc;
   logic [ERR_W-1:0] wrap_inc;

   // Compare and wrap detection on pre-edge values; on resync the wrap is
   // judged on the observed count because that is what the model adopts.
   always_comb begin
      cmp      = (count != expected);
      wrap_src = resync ? count : expected;
      wrap_hit = enable && (wrap_src == '1);
      err_inc  = ERR_W'(sat_inc(32'(error_count), ERR_W));
      wrap_inc = ERR_W'(sat_inc(32'(wrap_count), ERR_W));
   end

   // Model, tracking FSM and registered status outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= TRACK;
         expected    <= '0;
         mismatch    <= 1'b0;
         fault       <= 1'b0;
         error_count <= '0;
         wrap_pulse  <= 1'b0;
         wrap_count  <= '0;
      end else begin
         wrap_pulse <= wrap_hit;
         if (wrap_hit) begin
            wrap_count <= wrap_inc;
         end

         if (resync) begin
            state    <= TRACK;
            fault    <= 1'b0;
            mismatch <= 1'b0;
            expected <= count + WIDTH'(enable);
         end else begin
            expected <= expected + WIDTH'(enable);
            mismatch <= cmp;
            if (cmp) begin
               error_count <= err_inc;
            end
            case (state)
               TRACK: begin
                  if (cmp) begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end
               end
               FAULT: begin
                  fault <= 1'b1;
               end
               default: begin
                  state <= TRACK;
                  fault <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
